// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, FSM states and scanner timing constants for the keypad event queue
package keypad_pkg;
  localparam int KEY_CODE_W = 4;
  localparam logic [KEY_CODE_W-1:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
  localparam logic [KEY_CODE_W-1:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
  localparam logic [KEY_CODE_W-1:0] KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB;
  localparam logic [KEY_CODE_W-1:0] KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF;
  localparam int COL_PERIOD = 100_000;
  localparam int FRAME_PERIOD = 4 * COL_PERIOD;
  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD} state_t;
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: small synchronous FIFO; a pop in the same cycle frees the slot for a push even when full
module key_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= push && !do_push;
    end
  end
endmodule

// File: rtl/keypad_event_queue.sv
// keypad_event_queue: debounces column-multiplexed scanner hits into one event per press and queues them
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_HITS = 3,
  parameter int RELEASE_TIMEOUT = 450_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_100MHz,
  input  logic                  rst_n,
  input  logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_pressed,
  output logic                  evt_valid,
  output logic [KEY_CODE_W-1:0] evt_key,
  input  logic                  evt_ready,
  output logic                  key_held,
  output logic                  overflow
);
  localparam int TW = $clog2(RELEASE_TIMEOUT + 1);
  localparam int HW = $clog2(DEBOUNCE_HITS + 1);
  state_t state, state_n;
  logic [KEY_CODE_W-1:0] cand, cand_n, push_key;
  logic [HW-1:0] hits, hits_n;
  logic [TW-1:0] timer;
  logic key_prev, hit, at_timeout, push, fifo_empty;
  assign hit = key_pressed && !key_prev;
  assign at_timeout = timer == TW'(RELEASE_TIMEOUT);
  assign push_key = (state == ST_IDLE) ? key_code : cand;
  assign key_held = state == ST_HELD;
  assign evt_valid = !fifo_empty;
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      key_prev <= 1'b0;
      timer <= '0;
      state <= ST_IDLE;
      cand <= '0;
      hits <= '0;
    end else begin
      key_prev <= key_pressed;
      timer <= hit ? '0 : at_timeout ? timer : timer + 1'b1;
      state <= state_n;
      cand <= cand_n;
      hits <= hits_n;
    end
  end
  // A hit always takes priority over a timeout landing in the same cycle
  always_comb begin
    state_n = state;
    cand_n = cand;
    hits_n = hits;
    push = 1'b0;
    case (state)
      ST_IDLE:
        if (hit) begin
          cand_n = key_code;
          hits_n = HW'(1);
          push = DEBOUNCE_HITS == 1;
          state_n = (DEBOUNCE_HITS == 1) ? ST_HELD : ST_CONFIRM;
        end
      ST_CONFIRM:
        if (hit && key_code == cand) begin
          hits_n = hits + 1'b1;
          push = hits + 1'b1 == HW'(DEBOUNCE_HITS);
          state_n = push ? ST_HELD : ST_CONFIRM;
        end else if (hit) begin
          cand_n = key_code;
          hits_n = HW'(1);
        end else if (at_timeout) begin
          state_n = ST_IDLE;
        end
      ST_HELD:
        if (!hit && at_timeout) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  key_event_fifo #(.WIDTH(KEY_CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .push(push),
    .din(push_key),
    .pop(evt_ready),
    .dout(evt_key),
    .full(),
    .empty(fifo_empty),
    .overflow(overflow)
  );
endmodule

// File: tb/tb_keypad_event_queue.sv
// tb_keypad_event_queue: scoreboard bench with a 10-cycle-column / 40-cycle-frame scanner model
module tb_keypad_event_queue;
  localparam int HITS = 3;
  localparam int RT = 45;
  typedef struct {logic [3:0] key; int cyc;} exp_t;
  logic clk = 0, rst_n = 0, key_pressed = 0, evt_ready = 0;
  logic [3:0] key_code = '0;
  logic evt_valid, key_held, overflow;
  logic [3:0] evt_key;
  exp_t exp_q[$];
  exp_t e;
  int cyc = 0, nchk = 0, errs = 0, ov_cnt = 0, last_hit = 0, base = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  keypad_event_queue #(.DEBOUNCE_HITS(HITS), .RELEASE_TIMEOUT(RT), .FIFO_DEPTH(4)) dut (
    .clk_100MHz(clk),
    .rst_n(rst_n),
    .key_code(key_code),
    .key_pressed(key_pressed),
    .evt_valid(evt_valid),
    .evt_key(evt_key),
    .evt_ready(evt_ready),
    .key_held(key_held),
    .overflow(overflow)
  );
  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // One scanner frame: the key's column is active for 10 cycles, other columns for 30
  task automatic frame(input logic [3:0] code, input bit expect_evt);
    key_code = code;
    key_pressed = 1'b1;
    last_hit = cyc + 1;
    if (expect_evt) exp_q.push_back('{code, evt_ready ? cyc + 1 : -1});
    step(10);
    key_pressed = 1'b0;
    step(30);
  endtask
  task automatic press(input logic [3:0] code, input int frames, input bit expect_evt);
    for (int f = 0; f < frames; f++) frame(code, expect_evt && f == HITS - 1);
  endtask
  // Handshakes are sampled on the falling edge, ahead of the rising edge that completes them
  always @(negedge clk) begin
    if (rst_n) begin
      if (overflow) ov_cnt++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          nchk++;
          errs++;
          $display("FAIL unexpected_evt: got key %0h expected no event", evt_key);
        end else begin
          e = exp_q.pop_front();
          check("evt_key", int'(evt_key), int'(e.key));
          if (e.cyc >= 0) check("evt_latency", cyc, e.cyc);
        end
      end
    end
  end
  initial begin
    #2;
    check("rst_valid", evt_valid, 0);
    check("rst_key", evt_key, 0);
    check("rst_held", key_held, 0);
    check("rst_overflow", overflow, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    evt_ready = 1'b1;
    press(4'h7, 5, 1'b1);
    while (cyc < last_hit + RT) step();
    check("t1_held_last", key_held, 1);
    step();
    check("t1_released", key_held, 0);
    step(20);
    check("t1_pending", exp_q.size(), 0);
    press(4'h5, 2, 1'b0);
    step(60);
    press(4'h5, 3, 1'b1);
    step(60);
    check("t2_pending", exp_q.size(), 0);
    frame(4'hA, 1'b0);
    frame(4'hB, 1'b0);
    frame(4'hB, 1'b0);
    frame(4'hB, 1'b1);
    step(60);
    check("t3_pending", exp_q.size(), 0);
    evt_ready = 1'b0;
    base = ov_cnt;
    for (int k = 1; k <= 5; k++) begin
      press(4'(k), 3, k <= 4);
      step(60);
    end
    check("t4_overflow", ov_cnt - base, 1);
    check("t4_valid", evt_valid, 1);
    check("t4_head", evt_key, 1);
    evt_ready = 1'b1;
    step(8);
    check("t4_drained", evt_valid, 0);
    check("t4_pending", exp_q.size(), 0);
    evt_ready = 1'b0;
    base = ov_cnt;
    for (int k = 1; k <= 4; k++) begin
      press(4'(k), 3, 1'b1);
      step(60);
    end
    frame(4'h9, 1'b0);
    frame(4'h9, 1'b0);
    key_code = 4'h9;
    key_pressed = 1'b1;
    evt_ready = 1'b1;
    exp_q.push_back('{4'h9, -1});
    step();
    evt_ready = 1'b0;
    step(9);
    key_pressed = 1'b0;
    step(90);
    check("t5_no_overflow", ov_cnt - base, 0);
    check("t5_head", evt_key, 2);
    evt_ready = 1'b1;
    step(8);
    check("t5_drained", evt_valid, 0);
    check("t5_pending", exp_q.size(), 0);
    evt_ready = 1'b0;
    press(4'h6, 3, 1'b1);
    step(60);
    frame(4'h8, 1'b0);
    frame(4'h8, 1'b0);
    check("t6_pre_key", evt_key, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_key", evt_key, 0);
    check("t6_rst_held", key_held, 0);
    check("t6_rst_overflow", overflow, 0);
    exp_q.delete();
    step(3);
    rst_n = 1'b1;
    step(2);
    evt_ready = 1'b1;
    press(4'h8, 3, 1'b1);
    step(60);
    check("t6_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
